led_share_sched: RTL and testbench



---
 rtl/led_share_sched.sv | 134 +++++++++++++
 tb/tb_led_share_sched.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/led_share_sched.sv
// Round-robin scheduler that lends the single user LED to one requester at a time,
// showing its mode for DUR update ticks followed by a one-tick blank gap.
module led_share_sched #(
  parameter  int NUM_REQ   = 4,
  parameter  int TICK_BITS = 24,
  parameter  int BLINK_BIT = 22,
  parameter  int DUR_W     = 4,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                     CLK,
  input  logic                     RESETN,
  input  logic [NUM_REQ-1:0]       REQ,
  input  logic [2*NUM_REQ-1:0]     MODE,
  input  logic [DUR_W*NUM_REQ-1:0] DUR,
  input  logic                     ABORT,
  output logic [NUM_REQ-1:0]       GNT,
  output logic                     BUSY,
  output logic [ID_W-1:0]          ACTIVE_ID,
  output logic                     DONE,
  output logic                     LED
);

  typedef enum logic [1:0] {S_IDLE, S_SHOW, S_GAP} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [TICK_BITS-1:0] r_presc;
  logic [DUR_W-1:0]     r_cnt;
  logic [1:0]           r_mode;
  logic [ID_W-1:0]      r_ptr;
  logic [ID_W-1:0]      r_id;
  logic [NUM_REQ-1:0]   r_gnt;
  logic                 r_done;
  logic                 r_led;

  logic                 w_tick;
  logic                 w_found;
  logic [ID_W-1:0]      w_win;
  logic [ID_W-1:0]      w_idx;
  logic [1:0]           w_mode;
  logic [DUR_W-1:0]     w_dur;
  logic                 w_grant;
  logic                 w_last;
  logic                 w_led_nxt;
  logic [NUM_REQ-1:0]   w_gnt_nxt;

  assign w_tick = &r_presc;

  // Search upward from the last owner so every requester gets a turn.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_idx = ID_W'((int'(r_ptr) + i) % NUM_REQ);
      if (!w_found && REQ[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_mode = MODE[2*w_win +: 2];
  assign w_dur  = DUR[DUR_W*w_win +: DUR_W];

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_state_nxt = S_SHOW;
      S_SHOW: begin
        if (ABORT)                              w_state_nxt = S_IDLE;
        else if (w_tick && r_cnt == DUR_W'(1))  w_state_nxt = S_GAP;
      end
      S_GAP: begin
        if (ABORT || w_tick) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ABORT on the final tick suppresses DONE and blanks the LED immediately.
  always_comb begin
    w_grant   = (r_state == S_IDLE) && w_found;
    w_last    = (r_state == S_SHOW) && w_tick && (r_cnt == DUR_W'(1)) && !ABORT;
    w_gnt_nxt = w_grant ? (NUM_REQ'(1) << w_win) : '0;
    w_led_nxt = 1'b0;
    if (r_state == S_SHOW && !ABORT) begin
      case (r_mode)
        2'd0:    w_led_nxt = 1'b0;
        2'd1:    w_led_nxt = r_presc[BLINK_BIT];
        2'd2:    w_led_nxt = 1'b1;
        default: w_led_nxt = ~r_presc[BLINK_BIT];
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_presc <= '0;
      r_cnt   <= '0;
      r_mode  <= '0;
      r_ptr   <= ID_W'(NUM_REQ - 1);
      r_id    <= '0;
      r_gnt   <= '0;
      r_done  <= 1'b0;
      r_led   <= 1'b0;
    end else begin
      r_presc <= (w_grant || w_last) ? '0 : r_presc + 1'b1;
      r_gnt   <= w_gnt_nxt;
      r_done  <= w_last;
      r_led   <= w_led_nxt;
      if (w_grant) begin
        r_cnt  <= (w_dur == '0) ? DUR_W'(1) : w_dur;
        r_mode <= w_mode;
        r_ptr  <= w_win;
        r_id   <= w_win;
      end else if (r_state == S_SHOW && w_tick) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign GNT       = r_gnt;
  assign BUSY      = (r_state != S_IDLE);
  assign ACTIVE_ID = r_id;
  assign DONE      = r_done;
  assign LED       = r_led;

endmodule

// File: tb/tb_led_share_sched.sv
// Directed bench for led_share_sched at TICK_BITS=4, BLINK_BIT=2 (16-cycle tick).
module tb_led_share_sched;

  logic        CLK = 1'b0;
  logic        RESETN;
  logic [3:0]  REQ;
  logic [7:0]  MODE;
  logic [15:0] DUR;
  logic        ABORT;
  logic [3:0]  GNT;
  logic        BUSY;
  logic [1:0]  ACTIVE_ID;
  logic        DONE;
  logic        LED;

  int n_vec = 0;
  int n_err = 0;

  led_share_sched #(
    .NUM_REQ(4), .TICK_BITS(4), .BLINK_BIT(2), .DUR_W(4)
  ) dut (
    .CLK(CLK), .RESETN(RESETN), .REQ(REQ), .MODE(MODE), .DUR(DUR), .ABORT(ABORT),
    .GNT(GNT), .BUSY(BUSY), .ACTIVE_ID(ACTIVE_ID), .DONE(DONE), .LED(LED)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge of the first SHOW cycle; returns at the first IDLE cycle.
  task automatic observe_show(input int mode, input int dur, input string tag);
    int   bad_led = 0, bad_done = 0, bad_busy = 0, bad_gnt = 0;
    logic exp_led;
    for (int k = 1; k <= 16*dur + 16; k++) begin
      @(negedge CLK);
      if (k > 16*dur)     exp_led = 1'b0;
      else if (mode == 0) exp_led = 1'b0;
      else if (mode == 2) exp_led = 1'b1;
      else if (mode == 1) exp_led = ((k-1) & 4) != 0;
      else                exp_led = ((k-1) & 4) == 0;
      if (LED  !== exp_led)          bad_led++;
      if (DONE !== (k == 16*dur))    bad_done++;
      if (BUSY !== (k < 16*dur + 16)) bad_busy++;
      if (GNT  !== 4'b0000)          bad_gnt++;
    end
    check({tag, "_led_bad_cycles"},  bad_led,  0);
    check({tag, "_done_bad_cycles"}, bad_done, 0);
    check({tag, "_busy_bad_cycles"}, bad_busy, 0);
    check({tag, "_gnt_bad_cycles"},  bad_gnt,  0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESETN = 1'b0;
    REQ    = 4'b0000;
    ABORT  = 1'b0;
    @(negedge CLK);
    RESETN = 1'b1;
  endtask

  initial begin
    int bad;
    RESETN = 1'b0; REQ = '0; MODE = '0; DUR = '0; ABORT = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_led",  LED,       0);
    check("rst_busy", BUSY,      0);
    check("rst_gnt",  GNT,       0);
    check("rst_done", DONE,      0);
    check("rst_id",   ACTIVE_ID, 0);
    RESETN = 1'b1;

    bad = 0;
    repeat (100) begin
      @(negedge CLK);
      if (LED !== 1'b0 || BUSY !== 1'b0 || GNT !== 4'b0 || DONE !== 1'b0) bad++;
    end
    check("quiet_bad_cycles", bad, 0);

    // Single ON request, DUR=3
    REQ = 4'b0100; MODE = 8'h20; DUR = 16'h0300;
    @(negedge CLK);
    check("t2_gnt",  GNT,       4'b0100);
    check("t2_id",   ACTIVE_ID, 2);
    check("t2_busy", BUSY,      1);
    REQ = 4'b0000;
    observe_show(2, 3, "t2");

    // All requesting: order 0,1,2,3,0
    do_reset();
    REQ = 4'hF; MODE = 8'hAA; DUR = 16'h1111;
    for (int g = 0; g < 5; g++) begin
      @(negedge CLK);
      check($sformatf("t3_gnt%0d", g), GNT,       4'b0001 << (g % 4));
      check($sformatf("t3_id%0d",  g), ACTIVE_ID, g % 4);
      if (g == 4) REQ = 4'b0000;
      observe_show(2, 1, $sformatf("t3_show%0d", g));
    end

    // BLINK then BLINK_INV on requester 1
    REQ = 4'b0010; MODE = 8'h04; DUR = 16'h0020;
    @(negedge CLK);
    check("t4b_gnt", GNT, 4'b0010);
    REQ = 4'b0000;
    observe_show(1, 2, "t4b");
    REQ = 4'b0010; MODE = 8'h0C;
    @(negedge CLK);
    check("t4i_gnt", GNT, 4'b0010);
    REQ = 4'b0000;
    observe_show(3, 2, "t4i");

    // ABORT in IDLE is ignored; ABORT mid-SHOW; pending REQ[3] then served
    REQ = 4'b0001; ABORT = 1'b1; MODE = 8'hAA; DUR = 16'h1005;
    @(negedge CLK);
    check("t5_gnt0",  GNT,  4'b0001);
    check("t5_busy0", BUSY, 1);
    ABORT = 1'b0; REQ = 4'b1000;
    bad = 0;
    for (int k = 1; k <= 19; k++) begin
      @(negedge CLK);
      if (LED !== 1'b1 || GNT !== 4'b0 || DONE !== 1'b0 || BUSY !== 1'b1) bad++;
    end
    check("t5_show_bad_cycles", bad, 0);
    ABORT = 1'b1;
    @(negedge CLK);
    check("t5_abort_led",  LED,  0);
    check("t5_abort_busy", BUSY, 0);
    check("t5_abort_done", DONE, 0);
    ABORT = 1'b0;
    @(negedge CLK);
    check("t5_gnt3", GNT,       4'b1000);
    check("t5_id3",  ACTIVE_ID, 3);
    REQ = 4'b0000;
    observe_show(2, 1, "t5_r3");

    // DUR=0 behaves as one tick
    REQ = 4'b0001; DUR = 16'h0000;
    @(negedge CLK);
    check("t6_gnt", GNT, 4'b0001);
    REQ = 4'b0000;
    observe_show(2, 1, "t6_dur0");

    // Async reset mid-SHOW, then pointer back at requester 0 first
    REQ = 4'b0010;
    @(negedge CLK);
    check("t6_gnt1", GNT, 4'b0010);
    REQ = 4'b0000;
    repeat (5) @(negedge CLK);
    check("t6_led_pre", LED, 1);
    #2 RESETN = 1'b0;
    #1;
    check("t6_rst_led",  LED,       0);
    check("t6_rst_busy", BUSY,      0);
    check("t6_rst_id",   ACTIVE_ID, 0);
    check("t6_rst_done", DONE,      0);
    @(negedge CLK);
    RESETN = 1'b1;
    REQ = 4'hF;
    @(negedge CLK);
    check("t6_gnt_after", GNT, 4'b0001);
    REQ = 4'b0000;
    observe_show(2, 1, "t6_after");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
